// File: rtl/prim_diff_pkg.sv
// Shared types and constants for the multi-channel differential decoder.
package prim_diff_pkg;

  // Width of the per-channel skew counter; MaxSkew never exceeds 3.
  localparam int unsigned SkewCntW = 2;

  // Per-channel decoder state.
  typedef enum logic [1:0] {
    IsStd    = 2'd0,
    IsSkewed = 2'd1,
    SigInt   = 2'd2
  } diff_state_e;

  // Synchronous inputs have no skew window: p and n arrive together.
  function automatic int unsigned eff_max_skew(input int unsigned sync_stages,
                                               input int unsigned max_skew);
    return (sync_stages == 0) ? 0 : max_skew;
  endfunction

endpackage

// File: rtl/prim_diff_decode_chan.sv
// Single differential channel: input synchroniser, edge detect and the
// skew/integrity state machine. Outputs are combinational from the
// synchronised wires so the only latency is the synchroniser depth.
module prim_diff_decode_chan
  import prim_diff_pkg::*;
#(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned MaxSkew    = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        diff_pi,
  input  logic        diff_ni,
  output logic        level_o,
  output logic        rise_o,
  output logic        fall_o,
  output logic        sigint_o,
  output diff_state_e state_o
);

  localparam logic [SkewCntW-1:0] MaxSkewC = SkewCntW'(MaxSkew);
  localparam bit                  SkewEn   = (MaxSkew > 0);

  logic sp, sn;
  logic pq, nq;
  logic ok, ep, en;

  diff_state_e         state_q, state_d;
  logic [SkewCntW-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                rise, fall, sigint;

  if (SyncStages == 0) begin : gen_no_sync
    assign sp = diff_pi;
    assign sn = diff_ni;
  end else begin : gen_sync
    logic [1:0] sync2;
    // Reset value keeps the pair in the valid idle state p=0, n=1.
    prim_flop_2sync #(
      .Width      (2),
      .ResetValue (2'b10)
    ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    ({diff_ni, diff_pi}),
      .q_o    (sync2)
    );
    if (SyncStages == 3) begin : gen_stage3
      logic [1:0] sync3_q;
      // Optional third stage for slower-settling input paths.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync3_q <= 2'b10;
        else         sync3_q <= sync2;
      end
      assign {sn, sp} = sync3_q;
    end else begin : gen_stage2
      assign {sn, sp} = sync2;
    end
  end

  // One-cycle delayed copy of the synchronised pair for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pq <= 1'b0;
      nq <= 1'b1;
    end else begin
      pq <= sp;
      nq <= sn;
    end
  end

  assign ok = sp ^ sn;
  assign ep = sp ^ pq;
  assign en = sn ^ nq;

  // Next-state, level and pulse decode. Pulses are suppressed whenever
  // the channel reports an integrity error.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise    = 1'b0;
    fall    = 1'b0;
    sigint  = 1'b0;
    case (state_q)
      IsStd: begin
        if (ok) begin
          level_d = sp;
          if (ep && en) begin
            rise = sp;
            fall = ~sp;
          end
        end else if ((ep || en) && SkewEn) begin
          state_d = IsSkewed;
          cnt_d   = SkewCntW'(1);
        end else begin
          state_d = SigInt;
          sigint  = 1'b1;
        end
      end
      IsSkewed: begin
        if (ok) begin
          state_d = IsStd;
          cnt_d   = '0;
          level_d = sp;
          // Only a real level change produces a pulse; a glitch that
          // returns to the held level is swallowed.
          rise    = sp & ~level_q;
          fall    = ~sp & level_q;
        end else if (cnt_q < MaxSkewC) begin
          cnt_d = cnt_q + SkewCntW'(1);
        end else begin
          state_d = SigInt;
          cnt_d   = '0;
          sigint  = 1'b1;
        end
      end
      SigInt: begin
        if (ok) begin
          state_d = IsStd;
          level_d = sp;
        end else begin
          sigint = 1'b1;
        end
      end
      default: begin
        state_d = IsStd;
        cnt_d   = '0;
      end
    endcase
  end

  // State, skew counter and held level registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IsStd;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o  = level_d;
  assign rise_o   = rise;
  assign fall_o   = fall;
  assign sigint_o = sigint;
  assign state_o  = state_q;

endmodule

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser with a per-bit reset value.
module prim_flop_2sync #(
  parameter int unsigned           Width      = 16,
  parameter logic [Width-1:0]      ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage1_q, stage2_q;

  // Two back-to-back flops to settle metastability on asynchronous inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage1_q <= ResetValue;
      stage2_q <= ResetValue;
    end else begin
      stage1_q <= d_i;
      stage2_q <= stage1_q;
    end
  end

  assign q_o = stage2_q;

endmodule

// File: rtl/prim_diff_decode_mc.sv
// Multi-channel differential decoder: NumChan independent channels plus
// a shared sticky integrity flag.
module prim_diff_decode_mc
  import prim_diff_pkg::*;
#(
  parameter int unsigned NumChan    = 4,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned MaxSkew    = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumChan-1:0] diff_pi,
  input  logic [NumChan-1:0] diff_ni,
  input  logic               sigint_clr_i,
  output logic [NumChan-1:0] level_o,
  output logic [NumChan-1:0] rise_o,
  output logic [NumChan-1:0] fall_o,
  output logic [NumChan-1:0] event_o,
  output logic [NumChan-1:0] sigint_o,
  output logic               sigint_any_o,
  output logic               sigint_sticky_o
);

  localparam int unsigned EffSkew = eff_max_skew(SyncStages, MaxSkew);

  if (!(SyncStages == 0 || SyncStages == 2 || SyncStages == 3) ||
      MaxSkew > 3 || NumChan < 1 || NumChan > 32) begin : gen_param_check
    $error("prim_diff_decode_mc: unsupported parameter combination");
  end

  // Per-channel state, kept visible for debug probing.
  diff_state_e unused_chan_state [NumChan];

  logic sticky_q;

  for (genvar i = 0; i < NumChan; i++) begin : gen_chan
    prim_diff_decode_chan #(
      .SyncStages (SyncStages),
      .MaxSkew    (EffSkew)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .diff_pi  (diff_pi[i]),
      .diff_ni  (diff_ni[i]),
      .level_o  (level_o[i]),
      .rise_o   (rise_o[i]),
      .fall_o   (fall_o[i]),
      .sigint_o (sigint_o[i]),
      .state_o  (unused_chan_state[i])
    );
  end

  assign event_o      = rise_o | fall_o;
  assign sigint_any_o = |sigint_o;

  // Sticky integrity flag; a new error wins over a clear in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)           sticky_q <= 1'b0;
    else if (sigint_any_o) sticky_q <= 1'b1;
    else if (sigint_clr_i) sticky_q <= 1'b0;
  end

  assign sigint_sticky_o = sticky_q;

endmodule

// File: doc/prim_diff_decode_mc.md
PRIM_DIFF_DECODE_MC -- requirements
Module: prim_diff_decode_mc

Interface
REQ-001 Parameter NumChan, default 4, number of independent differential channels (1..32).
REQ-002 Parameter SyncStages, default 2, input synchroniser depth; 0 = synchronous inputs, 2 or 3 = asynchronous inputs.
REQ-003 Parameter MaxSkew, default 1, maximum consecutive cycles of tolerated p/n skew (0..3); forced to 0 when SyncStages=0.
REQ-004 clk_i  input  1  clock.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 diff_pi  input  NumChan  positive wire per channel.
REQ-007 diff_ni  input  NumChan  negative wire per channel.
REQ-008 sigint_clr_i  input  1  clears sticky integrity flag.
REQ-009 level_o  output  NumChan  decoded logical level.
REQ-010 rise_o / fall_o / event_o  output  NumChan each  single-cycle edge pulses; event_o = rise_o | fall_o.
REQ-011 sigint_o  output  NumChan  per-channel integrity error, live.
REQ-012 sigint_any_o  output  1  OR of sigint_o.
REQ-013 sigint_sticky_o  output  1  registered latched OR of sigint_o.

Function
REQ-014 Per channel: sp/sn = synchronised p/n (sync regs reset p=0, n=1); pq/nq = sp/sn delayed one cycle (reset 0/1); ok = sp^sn; ep = sp^pq; en = sn^nq.
REQ-015 Input-to-output latency SHALL be SyncStages cycles; decode logic from sp/sn to outputs is combinational.
REQ-016 Per-channel FSM states IsStd, IsSkewed, SigInt, plus skew counter skew_cnt (2 bits).
REQ-017 IsStd, ok: level <= sp; ep&&en SHALL pulse rise_o if sp=1, fall_o if sp=0.
REQ-018 IsStd, !ok, (ep||en) and MaxSkew>0: -> IsSkewed, skew_cnt=1, no event, no sigint.
REQ-019 IsStd, !ok otherwise: -> SigInt, sigint_o=1 same cycle.
REQ-020 IsSkewed, ok: -> IsStd, level <= sp; rise_o/fall_o pulses only if sp != held level; a return to the prior level produces no event.
REQ-021 IsSkewed, !ok: skew_cnt<MaxSkew -> increment, stay; else -> SigInt, sigint_o=1 same cycle.
REQ-022 SigInt: sigint_o=1 while !ok; ok -> IsStd, sigint_o=0 that cycle, level <= sp without event.
REQ-023 level_o SHALL equal the next-state level (updated same cycle); held unchanged in IsSkewed and SigInt.
REQ-024 rise_o, fall_o, event_o SHALL never assert in a cycle where sigint_o asserts.
REQ-025 sigint_sticky_o sets the cycle after any sigint_o=1; sigint_clr_i clears it the next cycle; simultaneous set and clear -> set wins.
REQ-026 Channels SHALL be fully independent; no cross-channel state.

Reset
REQ-027 On rst_ni low: all FSMs IsStd, skew_cnt=0, level 0, sync/edge regs p=0 n=1, sigint_sticky_o=0.
REQ-028 During/after reset: level_o=0, rise_o=fall_o=event_o=0, sigint_o=0, sigint_any_o=0 until non-reset input propagates.
REQ-029 Reset mid-skew or mid-SigInt SHALL return the channel to IsStd with no pulse on release.

Structure
REQ-030 Shared package prim_diff_pkg holds state enum diff_state_e {IsStd, IsSkewed, SigInt} and skew-counter width constant.
REQ-031 One sub-module prim_diff_decode_chan (single-channel sync + FSM), instantiated NumChan times via generate; synchroniser uses existing prim_flop_2sync when SyncStages=2.
REQ-032 Elaboration assertion: SyncStages in {0,2,3}, MaxSkew<=3, NumChan in 1..32.
REQ-033 Target size 120-400 lines RTL total.

Verification
REQ-034 SyncStages=2, MaxSkew=1, ch0 p/n 0/1 -> 1/0 same cycle -> rise_o[0] exactly once, 2 cycles later, level_o[0]=1.
REQ-035 MaxSkew=1, ch1 p rises, n falls 1 cycle later -> single rise_o[1] 3 cycles after p edge, sigint_o[1] never asserts.
REQ-036 MaxSkew=1, ch2 p rises, n falls 2 cycles later -> sigint_o[2]=1 one cycle, no rise_o, then level_o[2]=1 without event; sigint_sticky_o=1 until sigint_clr_i.
REQ-037 ch3 held p=n=1 for 5 cycles -> sigint_o[3]=1 continuously, level_o[3] stable, sigint_any_o=1; other channels unaffected.
REQ-038 SyncStages=0: p=n=0 for one cycle -> sigint_o high same cycle; clean edge -> rise/fall same cycle.
REQ-039 sigint_o and sigint_clr_i asserted same cycle -> sigint_sticky_o remains 1; rst_ni pulse mid-IsSkewed -> all outputs 0, no pulse after release.
